// File: rtl/icache_core_param.sv
// Set-associative instruction cache with line refill, uncached word reads and cache ops.
// Hit: data_ok one cycle after addr_ok. Miss: data_ok on the last refill beat.
// addr_ok is held low while busy. The bus request is held until rd_rdy.
module icache_core_param #(
    parameter int WAYS     = 2,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] virtual_addr,
    input  logic        tlb_excp_cancel_req,
    input  logic        uncache_en,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        cache_miss,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data,
    input  logic        icacop_op_en,
    input  logic [1:0]  cacop_op_mode,
    input  logic [31:0] cacop_op_addr,
    output logic        icache_unbusy,
    output logic        icache_hit
);

    localparam int SETS       = 1 << INDEX_W;
    localparam int LINE_WORDS = 1 << (OFFSET_W - 2);
    localparam int TAG_W      = 32 - INDEX_W - OFFSET_W;
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WORD_W     = OFFSET_W - 2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_UNCACHE, S_CACOP
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [WORD_W-1:0]  cnt_q, cnt_d;
    logic               cancel_q, cancel_d;
    logic               uc_wait_q, uc_wait_d;
    logic [1:0]         cop_mode_q, cop_mode_d;

    // Arrays: valid bits and replacement pointers are reset; tags and data are not.
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAY_W-1:0]   rr_q    [SETS];
    logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic [31:0]        data_q  [WAYS][SETS][LINE_WORDS];

    // Address fields of the latched request (also holds the cache-op address).
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WORD_W-1:0]  word;
    logic [WAY_W-1:0]   cop_way;

    assign idx     = addr_q[OFFSET_W +: INDEX_W];
    assign tag     = addr_q[31 -: TAG_W];
    assign word    = addr_q[OFFSET_W-1:2];
    assign cop_way = (WAYS > 1) ? addr_q[WAY_W-1:0] : '0;

    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] victim_sel;
    logic [WAY_W-1:0] rr_next;

    // Tag compare across all ways of the indexed set.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][WAY_W'(w)] && (tag_q[WAY_W'(w)][idx] == tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim choice: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        inv_found  = 1'b0;
        victim_sel = rr_q[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!inv_found && !valid_q[idx][WAY_W'(w)]) begin
                inv_found  = 1'b1;
                victim_sel = WAY_W'(w);
            end
        end
        rr_next = (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + WAY_W'(1);
    end

    // Control and request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            victim_q   <= '0;
            cnt_q      <= '0;
            cancel_q   <= 1'b0;
            uc_wait_q  <= 1'b0;
            cop_mode_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            victim_q   <= victim_d;
            cnt_q      <= cnt_d;
            cancel_q   <= cancel_d;
            uc_wait_q  <= uc_wait_d;
            cop_mode_q <= cop_mode_d;
        end
    end

    // Next-state logic; a cancel after the bus handshake only suppresses data_ok.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        victim_d   = victim_q;
        cnt_d      = cnt_q;
        cancel_d   = cancel_q;
        uc_wait_d  = uc_wait_q;
        cop_mode_d = cop_mode_q;
        case (state_q)
            S_IDLE: begin
                cancel_d  = 1'b0;
                uc_wait_d = 1'b0;
                cnt_d     = '0;
                if (icacop_op_en) begin
                    state_d    = S_CACOP;
                    addr_d     = cacop_op_addr;
                    cop_mode_d = cacop_op_mode;
                end else if (valid) begin
                    addr_d  = virtual_addr;
                    state_d = uncache_en ? S_UNCACHE : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (tlb_excp_cancel_req || hit_any) begin
                    state_d = S_IDLE;
                end else begin
                    victim_d = victim_sel;
                    state_d  = S_MISS;
                end
            end
            S_MISS: begin
                cnt_d = '0;
                if (tlb_excp_cancel_req) begin
                    state_d = S_IDLE;
                end else if (rd_rdy) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (tlb_excp_cancel_req) begin
                    cancel_d = 1'b1;
                end
                if (ret_valid) begin
                    if (ret_last) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + WORD_W'(1);
                    end
                end
            end
            S_UNCACHE: begin
                if (!uc_wait_q) begin
                    if (tlb_excp_cancel_req) begin
                        state_d = S_IDLE;
                    end else if (rd_rdy) begin
                        uc_wait_d = 1'b1;
                    end
                end else begin
                    if (tlb_excp_cancel_req) begin
                        cancel_d = 1'b1;
                    end
                    if (ret_valid) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CACOP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic             fill_en;
    logic             fill_last;
    logic             inv_en;
    logic             tag_clr;
    logic [WAY_W-1:0] inv_way;

    // Outputs and array write strobes decoded from the current state.
    always_comb begin
        addr_ok       = 1'b0;
        data_ok       = 1'b0;
        rdata         = '0;
        cache_miss    = 1'b0;
        rd_req        = 1'b0;
        rd_type       = 3'b000;
        rd_addr       = '0;
        icache_unbusy = 1'b0;
        icache_hit    = 1'b0;
        fill_en       = 1'b0;
        fill_last     = 1'b0;
        inv_en        = 1'b0;
        tag_clr       = 1'b0;
        inv_way       = '0;
        case (state_q)
            S_IDLE: begin
                icache_unbusy = 1'b1;
                addr_ok       = valid && !icacop_op_en;
            end
            S_LOOKUP: begin
                if (!tlb_excp_cancel_req) begin
                    if (hit_any) begin
                        data_ok    = 1'b1;
                        icache_hit = 1'b1;
                        rdata      = data_q[hit_way][idx][word];
                    end else begin
                        cache_miss = 1'b1;
                    end
                end
            end
            S_MISS: begin
                rd_req  = !tlb_excp_cancel_req;
                rd_type = 3'b100;
                rd_addr = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
            end
            S_REFILL: begin
                fill_en   = ret_valid;
                fill_last = ret_valid && ret_last;
                if (ret_valid && ret_last && !cancel_q && !tlb_excp_cancel_req) begin
                    data_ok = 1'b1;
                    // Earlier beats are already in the array; the final beat is still on the bus.
                    rdata   = (word == cnt_q) ? ret_data : data_q[victim_q][idx][word];
                end
            end
            S_UNCACHE: begin
                if (!uc_wait_q) begin
                    rd_req  = !tlb_excp_cancel_req;
                    rd_type = 3'b010;
                    rd_addr = addr_q;
                end else if (ret_valid && !cancel_q && !tlb_excp_cancel_req) begin
                    data_ok = 1'b1;
                    rdata   = ret_data;
                end
            end
            S_CACOP: begin
                case (cop_mode_q)
                    2'd0: begin
                        inv_en  = 1'b1;
                        tag_clr = 1'b1;
                        inv_way = cop_way;
                    end
                    2'd1: begin
                        inv_en  = 1'b1;
                        inv_way = cop_way;
                    end
                    2'd2: begin
                        inv_en  = hit_any;
                        inv_way = hit_way;
                    end
                    default: inv_en = 1'b0;
                endcase
            end
            default: icache_unbusy = 1'b0;
        endcase
    end

    // Valid bits and replacement pointers: set on refill completion, cleared by cache ops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[INDEX_W'(s)] <= '0;
                rr_q[INDEX_W'(s)]    <= '0;
            end
        end else begin
            if (fill_last) begin
                valid_q[idx][victim_q] <= 1'b1;
                rr_q[idx]              <= rr_next;
            end
            if (inv_en) begin
                valid_q[idx][inv_way] <= 1'b0;
            end
        end
    end

    // Tag array: written when a line completes, zeroed by the index-invalidate op.
    always_ff @(posedge clk) begin
        if (fill_last) begin
            tag_q[victim_q][idx] <= tag;
        end
        if (tag_clr) begin
            tag_q[inv_way][idx] <= '0;
        end
    end

    // Data array: one word per returned refill beat.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[victim_q][idx][cnt_q] <= ret_data;
        end
    end

endmodule

// File: tb/tb_icache_core_param.sv
// Directed bench for icache_core_param with a bus responder and an rdata scoreboard.
// Requests are driven #1 after the rising edge; outputs are sampled on the falling edge.
// Every bus request is granted on the cycle it is seen; beats follow back to back.
module tb_icache_core_param;

    localparam int OFFSET_W   = 4;
    localparam int LINE_WORDS = 1 << (OFFSET_W - 2);

    logic        clk;
    logic        reset;
    logic        valid;
    logic [31:0] virtual_addr;
    logic        tlb;
    logic        uncache_en;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        cache_miss;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;
    logic        icacop_op_en;
    logic [1:0]  cacop_op_mode;
    logic [31:0] cacop_op_addr;
    logic        icache_unbusy;
    logic        icache_hit;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    icache_core_param #(.WAYS(2), .INDEX_W(8), .OFFSET_W(OFFSET_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .valid               (valid),
        .virtual_addr        (virtual_addr),
        .tlb_excp_cancel_req (tlb),
        .uncache_en          (uncache_en),
        .addr_ok             (addr_ok),
        .data_ok             (data_ok),
        .rdata               (rdata),
        .cache_miss          (cache_miss),
        .rd_req              (rd_req),
        .rd_type             (rd_type),
        .rd_addr             (rd_addr),
        .rd_rdy              (rd_rdy),
        .ret_valid           (ret_valid),
        .ret_last            (ret_last),
        .ret_data            (ret_data),
        .icacop_op_en        (icacop_op_en),
        .cacop_op_mode       (cacop_op_mode),
        .cacop_op_addr       (cacop_op_addr),
        .icache_unbusy       (icache_unbusy),
        .icache_hit          (icache_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Backing memory contents seen on the bus.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {30'b0, a[3:2]} + 32'd1;
        if (a[31:4] == 28'h1C00000) return 32'h11 * w;
        if (a == 32'h1FE00000) return 32'hDEADBEEF;
        return a ^ 32'h5A5AA5A5;
    endfunction

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tg, obs, exp);
        end
    endtask

    // One fetch with bus responses; cancel_refill raises the cancel during the burst.
    task automatic fetch(input string tg, input logic [31:0] a, input logic unc,
                         input logic exp_hit, input logic cancel_refill);
        int n, b, oks, misses, rdreqs;
        logic pend, beating, fin, done;
        logic [31:0] base;
        n = unc ? 1 : LINE_WORDS;
        base = unc ? a : {a[31:OFFSET_W], {OFFSET_W{1'b0}}};
        b = 0; oks = 0; misses = 0; rdreqs = 0;
        pend = 0; beating = 0; fin = 0; done = 0;
        valid = 1'b1; virtual_addr = a; uncache_en = unc;
        @(negedge clk);
        chk({tg, " addr_ok"}, 32'(addr_ok), 32'd1);
        if (!cancel_refill) exp_q.push_back(mem_word(a));
        @(posedge clk); #1;
        valid = 1'b0; uncache_en = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (cache_miss) misses++;
            if (data_ok) begin
                oks++;
                if (exp_q.size() > 0) chk({tg, " rdata"}, rdata, exp_q.pop_front());
                chk({tg, " icache_hit"}, 32'(icache_hit), 32'(exp_hit));
                if (exp_hit) chk({tg, " hit latency"}, 32'(cyc), 32'd0);
                else chk({tg, " data_ok with ret_last"}, 32'(ret_last), 32'd1);
                done = 1;
            end
            if (rd_req && !pend && !beating && !fin) begin
                rdreqs++;
                chk({tg, " rd_addr"}, rd_addr, base);
                chk({tg, " rd_type"}, 32'(rd_type), unc ? 32'd2 : 32'd4);
                rd_rdy = 1'b1;
                pend = 1;
            end
            @(posedge clk); #1;
            if (beating) begin
                b++;
                if (b == n) begin
                    beating = 0; fin = 1; ret_valid = 1'b0; ret_last = 1'b0;
                end
            end
            if (pend) begin
                rd_rdy = 1'b0; pend = 0; beating = 1; b = 0;
            end
            if (beating) begin
                ret_valid = 1'b1;
                ret_data  = mem_word(base + 32'(4 * b));
                ret_last  = (b == n - 1);
                if (cancel_refill && b == 1) tlb = 1'b1;
            end
            if (cancel_refill && fin) done = 1;
        end
        tlb = 1'b0;
        chk({tg, " data_ok count"}, 32'(oks), cancel_refill ? 32'd0 : 32'd1);
        chk({tg, " cache_miss pulses"}, 32'(misses), (exp_hit || unc) ? 32'd0 : 32'd1);
        if (exp_hit) chk({tg, " rd_req on hit"}, 32'(rdreqs), 32'd0);
    endtask

    // Cache op issued together with a fetch request to show the op takes priority.
    task automatic cacop(input string tg, input logic [1:0] mode, input logic [31:0] a);
        icacop_op_en = 1'b1; cacop_op_mode = mode; cacop_op_addr = a;
        valid = 1'b1; virtual_addr = a;
        @(negedge clk);
        chk({tg, " addr_ok blocked"}, 32'(addr_ok), 32'd0);
        @(posedge clk); #1;
        icacop_op_en = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk({tg, " busy"}, 32'(icache_unbusy), 32'd0);
        chk({tg, " data_ok"}, 32'(data_ok), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic got;
        reset = 1'b1; valid = 1'b0; virtual_addr = '0; tlb = 1'b0; uncache_en = 1'b0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        icacop_op_en = 1'b0; cacop_op_mode = '0; cacop_op_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset addr_ok", 32'(addr_ok), 32'd0);
        chk("reset data_ok", 32'(data_ok), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset rd_req", 32'(rd_req), 32'd0);
        chk("reset cache_miss", 32'(cache_miss), 32'd0);
        chk("reset icache_hit", 32'(icache_hit), 32'd0);
        chk("reset unbusy", 32'(icache_unbusy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Cold miss, then hit in the same line.
        fetch("cold A", 32'h1C000000, 1'b0, 1'b0, 1'b0);
        fetch("hit A+8", 32'h1C000008, 1'b0, 1'b1, 1'b0);

        // Three lines in set 0 of a 2-way cache: the third evicts way 0.
        fetch("fill B", 32'h1C001004, 1'b0, 1'b0, 1'b0);
        fetch("fill C", 32'h1C002000, 1'b0, 1'b0, 1'b0);
        fetch("hit B", 32'h1C001004, 1'b0, 1'b1, 1'b0);
        fetch("A evicted", 32'h1C000000, 1'b0, 1'b0, 1'b0);

        // Uncached word read does not allocate.
        fetch("uncache", 32'h1FE00000, 1'b1, 1'b0, 1'b0);
        fetch("cached after uncache", 32'h1FE00000, 1'b0, 1'b0, 1'b0);

        // Cancel during lookup of a miss.
        valid = 1'b1; virtual_addr = 32'h1C005040;
        @(negedge clk);
        chk("cancel addr_ok", 32'(addr_ok), 32'd1);
        @(posedge clk); #1;
        valid = 1'b0; tlb = 1'b1;
        @(negedge clk);
        chk("cancel lookup data_ok", 32'(data_ok), 32'd0);
        chk("cancel lookup rd_req", 32'(rd_req), 32'd0);
        @(posedge clk); #1;
        tlb = 1'b0;
        @(negedge clk);
        chk("cancel unbusy", 32'(icache_unbusy), 32'd1);
        chk("cancel rd_req after", 32'(rd_req), 32'd0);
        @(posedge clk); #1;
        fetch("after cancel misses", 32'h1C005040, 1'b0, 1'b0, 1'b0);

        // Hit-invalidate removes only the hitting way.
        cacop("cacop2", 2'd2, 32'h1C000000);
        fetch("other way survives", 32'h1FE00000, 1'b0, 1'b1, 1'b0);
        fetch("cacop2 miss", 32'h1C000000, 1'b0, 1'b0, 1'b0);

        // Index-invalidate of way 0, set 0.
        cacop("cacop0", 2'd0, 32'h1C000000);
        fetch("cacop0 miss", 32'h1FE00000, 1'b0, 1'b0, 1'b0);
        fetch("cacop0 way1 hit", 32'h1C000000, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a refill burst.
        valid = 1'b1; virtual_addr = 32'h1C003000;
        @(negedge clk);
        chk("rst-refill addr_ok", 32'(addr_ok), 32'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rd_req) got = 1'b1;
        end
        chk("rst-refill rd_req seen", 32'(got), 32'd1);
        rd_rdy = 1'b1;
        @(posedge clk); #1;
        rd_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ret_valid = 1'b1; ret_data = mem_word(32'h1C003000 + 32'(4 * i)); ret_last = 1'b0;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        ret_data = mem_word(32'h1C003008);
        @(negedge clk);
        chk("rst-refill unbusy", 32'(icache_unbusy), 32'd1);
        chk("rst-refill data_ok", 32'(data_ok), 32'd0);
        chk("rst-refill rd_req", 32'(rd_req), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ret_data = mem_word(32'h1C00300C); ret_last = 1'b1;
        @(negedge clk);
        chk("stray beat data_ok", 32'(data_ok), 32'd0);
        chk("stray beat unbusy", 32'(icache_unbusy), 32'd1);
        @(posedge clk); #1;
        ret_valid = 1'b0; ret_last = 1'b0;
        fetch("after reset miss", 32'h1C003000, 1'b0, 1'b0, 1'b0);
        fetch("valid cleared", 32'h1C000000, 1'b0, 1'b0, 1'b0);

        // Cancel during refill: no data_ok, but the line is still installed.
        fetch("cancel refill", 32'h1C006080, 1'b0, 1'b0, 1'b1);
        fetch("cancelled line hits", 32'h1C006080, 1'b0, 1'b1, 1'b0);

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_core_param.md
ICACHE_CORE_PARAM -- requirements
Module: icache_core_param

Interface
REQ-001 Parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 Parameter INDEX_W, default 8, set-index bits; SETS = 2^INDEX_W.
REQ-003 Parameter OFFSET_W, default 4, byte-offset bits; LINE_WORDS = 2^(OFFSET_W-2); legal range 3..6.
REQ-004 Tag width SHALL be TAG_W = 32-INDEX_W-OFFSET_W; the address is used untranslated (physical == virtual_addr).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 valid  in  1  fetch request; virtual_addr  in  32  fetch PC, word aligned.
REQ-008 tlb_excp_cancel_req  in  1  aborts the outstanding fetch.
REQ-009 uncache_en  in  1  sampled with the request; forces a single-word bus read.
REQ-010 addr_ok  out  1  request accepted; data_ok  out  1  rdata valid; rdata  out  32  instruction.
REQ-011 cache_miss  out  1  one-cycle pulse per cacheable miss.
REQ-012 rd_req  out  1; rd_type  out  3 (3'b010 word, 3'b100 line); rd_addr  out  32; rd_rdy  in  1; ret_valid  in  1; ret_last  in  1; ret_data  in  32.
REQ-013 icacop_op_en  in  1; cacop_op_mode  in  2; cacop_op_addr  in  32  cache-op address.
REQ-014 icache_unbusy  out  1  high only in IDLE; icache_hit  out  1  high with data_ok on a lookup hit.

Function
REQ-015 States: IDLE, LOOKUP, MISS, REFILL, UNCACHE, CACOP.
REQ-016 IDLE: addr_ok = valid && !icacop_op_en; on accept, latch address and uncache_en, go to LOOKUP (uncache_en=0) or UNCACHE (uncache_en=1); icacop_op_en has priority over valid.
REQ-017 LOOKUP compares latched tag against all ways of the indexed set; hit -> data_ok=1, icache_hit=1, rdata=selected word, return to IDLE; hit latency = 1 cycle after addr_ok.
REQ-018 LOOKUP miss -> pulse cache_miss, select victim way, go to MISS.
REQ-019 Victim = first invalid way (lowest index); if all valid, per-set round-robin pointer, advanced by 1 modulo WAYS on each refill into that set.
REQ-020 MISS: rd_req=1, rd_type=3'b100, rd_addr={tag,index,OFFSET_W'b0}; held until rd_rdy=1, then REFILL.
REQ-021 REFILL: each ret_valid beat writes ret_data to word counter position (counter starts 0, increments per beat); on ret_last the line's valid bit and tag are set, counter clears, data_ok=1 with rdata = requested word, return to IDLE.
REQ-022 Critical-word return SHALL NOT precede ret_last; data_ok fires exactly once per accepted request.
REQ-023 UNCACHE: rd_req=1, rd_type=3'b010, rd_addr=latched address; after rd_rdy, first ret_valid gives data_ok with rdata=ret_data; no array write.
REQ-024 tlb_excp_cancel_req in LOOKUP -> IDLE, no data_ok, no bus request; in MISS before handshake -> IDLE, no bus request; in REFILL/UNCACHE after handshake -> burst completes (refill still writes the line), data_ok suppressed.
REQ-025 CACOP (one cycle, then IDLE): mode 0 clears valid+tag of way cacop_op_addr[log2(WAYS)-1:0] at index; mode 1 clears valid of that way; mode 2 clears valid of hitting way, no-op on miss; mode 3 no-op.
REQ-026 rd_req, data_ok, cache_miss, icache_hit SHALL be low in all states not named above.

Reset
REQ-027 Reset SHALL drive state to IDLE, clear all valid bits, round-robin pointers and word counter; outputs addr_ok=0 (until valid), data_ok=0, rdata=0, rd_req=0, cache_miss=0, icache_hit=0, icache_unbusy=1.
REQ-028 Reset mid-refill SHALL abandon the burst; later ret_valid beats are ignored in IDLE.

Verification
REQ-029 Cold fetch 0x1C000000, line of 4 beats 0x11..0x44 -> cache_miss pulse, rd_addr=0x1C000000, rd_type=100, data_ok with rdata=0x11 on last beat.
REQ-030 Refetch 0x1C000008 -> data_ok next cycle, rdata=0x33, icache_hit=1, no rd_req.
REQ-031 WAYS=2: fill 0x1C000000, 0x1C001000, 0x1C002000 (same index) -> third replaces way 0; 0x1C000000 then misses.
REQ-032 uncache_en=1 fetch 0x1FE00000, ret_data=0xDEADBEEF -> rd_type=010, data_ok rdata=0xDEADBEEF; refetch cached misses.
REQ-033 Cancel asserted in LOOKUP for a miss -> no rd_req, no data_ok, icache_unbusy=1 next cycle.
REQ-034 cacop mode 2 on 0x1C000000 after fill -> subsequent fetch misses; reset during REFILL -> valid bits 0, icache_unbusy=1.
